// File: rtl/transmit_ordered_set.sv
// transmit_ordered_set
// GMII transmit side of a 1000BASE-X PCS: turns the tx_en/tx_er/txd stream
// into ordered-set requests (/I/ /S/ /D/ /T/ /R/ /V/) for the code-group
// encoder. It keeps /S/ on an even code-group position and pads the end of
// a packet with /R/ so that the idle that follows starts even.
//
// Optional feature: define CARRIER_EXT_EN to add the EXTEND state, which
// handles carrier extension after /T/. Without it, tx_er while tx_en=0 is
// ignored.
//
// Stream contract: there is no valid/ready pair. A code group is produced
// on every gtx_clk edge, and every output is registered. The inputs sampled
// at edge k show up on the outputs just after edge k.
module transmit_ordered_set (
    input  logic       gtx_clk,
    input  logic       reset_l,
    input  logic [7:0] txd,
    input  logic       tx_en,
    input  logic       tx_er,
    input  logic       xmit_data,
    input  logic       receiving,
    output logic [2:0] tx_o_set,
    output logic [7:0] tx_data,
    output logic       tx_even,
    output logic       transmitting,
    output logic       col,
    output logic [7:0] tx_err_cnt,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] OS_I = 3'd0;
    localparam logic [2:0] OS_S = 3'd1;
    localparam logic [2:0] OS_D = 3'd2;
    localparam logic [2:0] OS_T = 3'd3;
    localparam logic [2:0] OS_R = 3'd4;
    localparam logic [2:0] OS_V = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SOP    = 3'd1,
        S_DATA   = 3'd2,
        S_EOP_T  = 3'd3,
        S_EOP_R1 = 3'd4,
        S_EOP_R2 = 3'd5
`ifdef CARRIER_EXT_EN
        ,
        S_EXTEND = 3'd6
`endif
    } state_t;

    state_t state;
    // Set once the current packet has been counted as errored.
    logic   pkt_err;

`ifdef CARRIER_EXT_EN
    // Carrier-extend request: tx_en low, tx_er high, txd = 8'h0F.
    logic   ext_cond;

    // Decode the carrier-extend request from the GMII inputs.
    always_comb begin
        ext_cond = !tx_en && tx_er && (txd == 8'h0F);
    end
`endif

    // The FSM state is exposed for debugging.
    assign state_dbg = state;

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Ordered-set FSM. It drives every registered output, the position
    // parity, the collision flag and the error count.
    always_ff @(posedge gtx_clk or negedge reset_l) begin
        if (!reset_l) begin
            state        <= S_IDLE;
            tx_o_set     <= OS_I;
            tx_data      <= 8'h00;
            tx_even      <= 1'b1;
            transmitting <= 1'b0;
            col          <= 1'b0;
            tx_err_cnt   <= 8'h00;
            pkt_err      <= 1'b0;
        end else begin
            tx_even <= ~tx_even;
            col     <= transmitting & receiving;

            if (!xmit_data) begin
                // Forced idle. An abort in the middle of a packet counts as an error.
                state        <= S_IDLE;
                tx_o_set     <= OS_I;
                tx_data      <= 8'h00;
                transmitting <= 1'b0;
                if ((state == S_SOP || state == S_DATA) && !pkt_err) begin
                    pkt_err    <= 1'b1;
                    tx_err_cnt <= sat_inc(tx_err_cnt);
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        tx_data <= 8'h00;
                        // Start only when the next group is even, so /S/ lands even.
                        if (tx_en && !tx_even) begin
                            state        <= S_SOP;
                            tx_o_set     <= OS_S;
                            transmitting <= 1'b1;
                            pkt_err      <= 1'b0;
                        end else begin
                            state        <= S_IDLE;
                            tx_o_set     <= OS_I;
                            transmitting <= 1'b0;
                        end
                    end

                    S_SOP, S_DATA: begin
                        if (tx_en) begin
                            state        <= S_DATA;
                            transmitting <= 1'b1;
                            if (tx_er) begin
                                tx_o_set <= OS_V;
                                tx_data  <= 8'h00;
                                if (!pkt_err) begin
                                    pkt_err    <= 1'b1;
                                    tx_err_cnt <= sat_inc(tx_err_cnt);
                                end
                            end else begin
                                tx_o_set <= OS_D;
                                tx_data  <= txd;
                            end
                        end else begin
                            state        <= S_EOP_T;
                            tx_o_set     <= OS_T;
                            tx_data      <= 8'h00;
                            transmitting <= 1'b0;
                        end
                    end

                    S_EOP_T: begin
                        state        <= S_EOP_R1;
                        tx_o_set     <= OS_R;
                        tx_data      <= 8'h00;
                        transmitting <= 1'b0;
                    end

                    S_EOP_R1: begin
                        tx_data      <= 8'h00;
                        transmitting <= 1'b0;
`ifdef CARRIER_EXT_EN
                        if (ext_cond) begin
                            state        <= S_EXTEND;
                            tx_o_set     <= OS_R;
                            transmitting <= 1'b1;
                        end else
`endif
                        // Add a second /R/ when needed so the idle that follows starts even.
                        if (!tx_even) begin
                            state    <= S_IDLE;
                            tx_o_set <= OS_I;
                        end else begin
                            state    <= S_EOP_R2;
                            tx_o_set <= OS_R;
                        end
                    end

                    S_EOP_R2: begin
                        state        <= S_IDLE;
                        tx_o_set     <= OS_I;
                        tx_data      <= 8'h00;
                        transmitting <= 1'b0;
                    end

`ifdef CARRIER_EXT_EN
                    S_EXTEND: begin
                        tx_data <= 8'h00;
                        if (ext_cond) begin
                            state        <= S_EXTEND;
                            tx_o_set     <= OS_R;
                            transmitting <= 1'b1;
                        end else if (tx_er) begin
                            // A malformed extension becomes /V/ and marks the packet errored.
                            state        <= S_EXTEND;
                            tx_o_set     <= OS_V;
                            transmitting <= 1'b1;
                            if (!pkt_err) begin
                                pkt_err    <= 1'b1;
                                tx_err_cnt <= sat_inc(tx_err_cnt);
                            end
                        end else if (!tx_even) begin
                            state        <= S_IDLE;
                            tx_o_set     <= OS_I;
                            transmitting <= 1'b0;
                        end else begin
                            state        <= S_EOP_R2;
                            tx_o_set     <= OS_R;
                            transmitting <= 1'b0;
                        end
                    end
`endif

                    default: begin
                        state        <= S_IDLE;
                        tx_o_set     <= OS_I;
                        tx_data      <= 8'h00;
                        transmitting <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
